icebus_tx_scheduler: RTL
========================

// Module: icebus_tx_scheduler
// PURPOSE
//  Sequences the single iCEboard UART link between all motors. Raises a periodic sweep at
//  update_frequency_Hz and grants the frame builder one motor/frame-type at a time (round-robin).
//  Waits for tx completion and the motor's reply, retries on CRC error/timeout, reports failures.
//  Sits between the Avalon register file (config-dirty pulses, rate) and the UART framer.
// PARAMETERS
//  NUMBER_OF_MOTORS  8           motors on the bus (1..256)
//  CLOCK_FREQ_HZ     50_000_000  clk frequency, tick accumulator modulus
//  TIMEOUT_CYCLES    5000        clk cycles from tx_done to give up waiting for reply
//  MAX_RETRIES       2           re-sends per transaction after the first attempt
// PORTS
//  clk                  in   1   system clock
//  reset_n              in   1   asynchronous, active-low reset
//  enable               in   1   scheduler enable
//  update_frequency_Hz  in   32  sweep rate; 0 = no sweeps
//  cfg_dirty_set        in   N   per-motor pulse: gains/limits written, CONFIG frame needed
//  req_valid            out  1   frame request to framer
//  req_type             out  2   0 SETPOINT, 1 CONFIG (2,3 reserved)
//  req_motor            out  8   motor index of request
//  req_ready            in   1   framer accepts request (valid&&ready = handshake)
//  tx_done              in   1   framer finished shifting the frame (1-cycle pulse)
//  rx_ack_valid         in   1   reply frame received (1-cycle pulse)
//  rx_ack_motor         in   8   motor id in reply
//  rx_crc_ok            in   1   reply CRC correct, qualifies rx_ack_valid
//  fail_pulse           out  1   transaction abandoned after MAX_RETRIES
//  fail_motor           out  8   motor of fail_pulse
//  sweep_overrun        out  1   1-cycle pulse: tick while previous sweep still pending
//  busy                 out  1   state != IDLE or pending/dirty mask nonzero
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; pending, dirty, rr pointer, retry count, accumulator 0.
//  - Tick: acc += update_frequency_Hz each clk; if acc+rate >= CLOCK_FREQ_HZ, acc <= acc+rate-CLOCK_FREQ_HZ,
//    tick=1. Rate 0 -> never ticks; rate >= CLOCK_FREQ_HZ -> tick every cycle (clamp). 33-bit compare.
//  - Tick with enable=1: pending <= all ones; if pending was nonzero, sweep_overrun pulses (mask merges).
//  - dirty[m] set by cfg_dirty_set[m]; set beats clear in the same cycle. enable=0 clears pending, keeps dirty.
//  - FSM IDLE: if enable and (pending|dirty)!=0, select first set bit at/after rr pointer (wraps N-1->0);
//    type = CONFIG if dirty[m] else SETPOINT; retry count 0 -> ISSUE (decision 1 cycle).
//  - ISSUE: req_valid=1, req_type/req_motor stable until req_ready; on handshake -> WAIT_TX.
//  - WAIT_TX: on tx_done -> WAIT_ACK, timer cleared.
//  - WAIT_ACK: rx_ack_valid && rx_ack_motor==m && rx_crc_ok -> success: clear dirty[m] (CONFIG) or
//    pending[m] (SETPOINT); rr <= m+1; -> IDLE. CONFIG success leaves pending[m] set (SETPOINT next).
//    Matching motor with crc bad, or timer==TIMEOUT_CYCLES-1 -> retry: count<MAX_RETRIES -> ISSUE, count++;
//    else fail_pulse=1, fail_motor=m, clear pending[m] (dirty kept, retried next pick), rr <= m+1, -> IDLE.
//  - Replies from other motors, or any rx_ack_valid outside WAIT_ACK: ignored.
//  - enable drop mid-transaction: current transaction completes (incl. retries), then stays IDLE.
//  - Reset mid-operation: immediate return to reset state, req_valid low same edge.
//  - Latency: tick -> req_valid 2 cycles (pending reg, IDLE decide).
// STRUCTURE
//  Package icebus_pkg: frame_type_e {FT_SETPOINT=0, FT_CONFIG=1}, sched_state_e {IDLE,ISSUE,WAIT_TX,WAIT_ACK},
//  MOTOR_IDX_W=8. Sub-module icebus_tick_gen (phase accumulator, clamp, tick pulse).
//  Round-robin first-set search is a function inside this module.
// TESTING
//  1 N=4, CLOCK_FREQ_HZ=1000, rate=100, enable=1, instant ready/tx_done/ack -> one tick per 10 clk, requests
//    motors 0,1,2,3 SETPOINT in order per sweep.
//  2 cfg_dirty_set=4'b0100 between sweeps -> motor 2 gets CONFIG then SETPOINT; dirty[2] clears only on ack.
//  3 no reply for motor 1, TIMEOUT_CYCLES=20, MAX_RETRIES=2 -> 3 requests, fail_pulse once with fail_motor=1,
//    sweep continues at motor 2.
//  4 motor 0 reply rx_crc_ok=0 once then good -> exactly 2 requests for motor 0, no fail_pulse.
//  5 rate=1000 with acks delayed 50 clk -> sweep_overrun pulses, no duplicate requests, rr order kept.
//  6 reset_n low during WAIT_ACK / enable low mid-sweep -> outputs 0 at once / current finishes then idle, dirty retained.

Source files
------------

// File: rtl/icebus_pkg.sv
// icebus_pkg: shared types and widths for the iCEboard UART transmit scheduler
package icebus_pkg;
  localparam int MOTOR_IDX_W = 8;
  typedef enum logic [1:0] {FT_SETPOINT = 2'd0, FT_CONFIG = 2'd1} frame_type_e;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_TX, WAIT_ACK} sched_state_e;
endpackage

// File: rtl/icebus_tick_gen.sv
// icebus_tick_gen: phase accumulator raising one tick per 1/rate seconds
//   clk, reset_n : clock, async active-low reset
//   i_rate       : ticks per second, 0 = never, >= CLOCK_FREQ_HZ = every cycle
//   o_tick       : combinational tick for the current cycle
module icebus_tick_gen #(
  parameter int CLOCK_FREQ_HZ = 50_000_000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] i_rate,
  output logic        o_tick
);
  logic [31:0] r_acc;
  logic [32:0] w_sum;
  logic        w_clamp;
  assign w_sum   = {1'b0, r_acc} + {1'b0, i_rate};
  assign w_clamp = {1'b0, i_rate} >= 33'(CLOCK_FREQ_HZ);
  assign o_tick  = w_clamp || (w_sum >= 33'(CLOCK_FREQ_HZ));
  // a clamped rate ticks every cycle and leaves the phase untouched
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_acc <= '0;
    else if (!w_clamp) r_acc <= o_tick ? 32'(w_sum - 33'(CLOCK_FREQ_HZ)) : w_sum[31:0];
endmodule

// File: rtl/icebus_tx_scheduler.sv
// icebus_tx_scheduler: round-robin sequencing of SETPOINT/CONFIG frames to all motors
//   clk, reset_n               : clock, async active-low reset
//   enable, update_frequency_Hz: scheduler enable, sweep rate
//   cfg_dirty_set              : per-motor request for a CONFIG frame
//   req_valid/type/motor/ready : frame request handshake to the framer
//   tx_done, rx_ack_*          : framer completion and motor reply
//   fail_pulse/motor           : transaction abandoned after all retries
//   sweep_overrun, busy        : sweep tick hit a pending sweep, activity flag
module icebus_tx_scheduler
  import icebus_pkg::*;
#(
  parameter int NUMBER_OF_MOTORS = 8,
  parameter int CLOCK_FREQ_HZ    = 50_000_000,
  parameter int TIMEOUT_CYCLES   = 5000,
  parameter int MAX_RETRIES      = 2
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        enable,
  input  logic [31:0]                 update_frequency_Hz,
  input  logic [NUMBER_OF_MOTORS-1:0] cfg_dirty_set,
  output logic                        req_valid,
  output logic [1:0]                  req_type,
  output logic [MOTOR_IDX_W-1:0]      req_motor,
  input  logic                        req_ready,
  input  logic                        tx_done,
  input  logic                        rx_ack_valid,
  input  logic [MOTOR_IDX_W-1:0]      rx_ack_motor,
  input  logic                        rx_crc_ok,
  output logic                        fail_pulse,
  output logic [MOTOR_IDX_W-1:0]      fail_motor,
  output logic                        sweep_overrun,
  output logic                        busy
);
  localparam int N = NUMBER_OF_MOTORS;
  sched_state_e           r_state, w_next;
  frame_type_e            r_type;
  logic [N-1:0]           r_pending, r_dirty, w_onehot, w_clr_pend, w_clr_dirty, w_pick_sh;
  logic [MOTOR_IDX_W-1:0] r_rr, r_motor, r_fail_motor, w_pick, w_rr_next;
  logic [31:0]            r_timer;
  logic [7:0]             r_retry;
  logic                   r_fail, r_overrun, w_tick, w_match, w_timeout;
  logic                   w_start, w_success, w_retry, w_fail;

  // first set bit of mask at or after ptr, wrapping N-1 -> 0
  function automatic logic [MOTOR_IDX_W-1:0] rr_first(input logic [N-1:0] mask,
                                                      input logic [MOTOR_IDX_W-1:0] ptr);
    logic [MOTOR_IDX_W-1:0] j;
    logic [N-1:0]           s;
    rr_first = ptr;
    for (int k = N - 1; k >= 0; k--) begin
      j = MOTOR_IDX_W'((int'(ptr) + k) % N);
      s = mask >> j;
      if (s[0]) rr_first = j;
    end
  endfunction

  icebus_tick_gen #(.CLOCK_FREQ_HZ(CLOCK_FREQ_HZ)) u_tick (
    .clk    (clk),
    .reset_n(reset_n),
    .i_rate (update_frequency_Hz),
    .o_tick (w_tick)
  );

  assign w_pick      = rr_first(r_pending | r_dirty, r_rr);
  assign w_pick_sh   = r_dirty >> w_pick;
  assign w_onehot    = N'(1) << r_motor;
  assign w_rr_next   = (r_motor == MOTOR_IDX_W'(N - 1)) ? '0 : r_motor + 1'b1;
  assign w_match     = rx_ack_valid && (rx_ack_motor == r_motor);
  assign w_timeout   = r_timer == 32'(TIMEOUT_CYCLES - 1);
  // a CONFIG success leaves pending set so the SETPOINT follows later
  assign w_clr_pend  = ((w_success && r_type == FT_SETPOINT) || w_fail) ? w_onehot : '0;
  assign w_clr_dirty = (w_success && r_type == FT_CONFIG) ? w_onehot : '0;
  assign req_valid     = r_state == ISSUE;
  assign req_type      = r_type;
  assign req_motor     = r_motor;
  assign fail_pulse    = r_fail;
  assign fail_motor    = r_fail_motor;
  assign sweep_overrun = r_overrun;
  assign busy          = (r_state != IDLE) || |(r_pending | r_dirty);

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_state <= IDLE;
    else r_state <= w_next;

  always_comb begin
    w_next    = r_state;
    w_start   = 1'b0;
    w_success = 1'b0;
    w_retry   = 1'b0;
    w_fail    = 1'b0;
    case (r_state)
      IDLE: if (enable && |(r_pending | r_dirty)) begin
        w_start = 1'b1;
        w_next  = ISSUE;
      end
      ISSUE:   w_next = req_ready ? WAIT_TX : ISSUE;
      WAIT_TX: w_next = tx_done ? WAIT_ACK : WAIT_TX;
      WAIT_ACK: if (w_match && rx_crc_ok) begin
        w_success = 1'b1;
        w_next    = IDLE;
      end else if (w_match || w_timeout) begin
        w_retry = r_retry < 8'(MAX_RETRIES);
        w_fail  = !w_retry;
        w_next  = w_retry ? ISSUE : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_pending    <= '0;
      r_dirty      <= '0;
      r_rr         <= '0;
      r_motor      <= '0;
      r_type       <= FT_SETPOINT;
      r_retry      <= '0;
      r_timer      <= '0;
      r_fail       <= 1'b0;
      r_fail_motor <= '0;
      r_overrun    <= 1'b0;
    end else begin
      // a new sweep re-arms every motor, overriding this cycle's completion
      r_pending <= !enable ? '0 : w_tick ? '1 : r_pending & ~w_clr_pend;
      r_dirty   <= (r_dirty & ~w_clr_dirty) | cfg_dirty_set;
      r_overrun <= w_tick && enable && |r_pending;
      r_fail    <= w_fail;
      r_timer   <= (r_state == WAIT_ACK) ? r_timer + 32'd1 : '0;
      if (w_fail) r_fail_motor <= r_motor;
      if (w_start) begin
        r_motor <= w_pick;
        r_type  <= w_pick_sh[0] ? FT_CONFIG : FT_SETPOINT;
        r_retry <= '0;
      end
      if (w_retry) r_retry <= r_retry + 8'd1;
      if (w_success || w_fail) r_rr <= w_rr_next;
    end
endmodule
